// File: rtl/ar_arb_pkg.sv
// ar_arb_pkg: shared state encoding, default sizes and round-robin pick function for the merge arbiters
package ar_arb_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ = 4;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
    function automatic int rr_pick(input logic [15:0] req, input int last, input int nreq = DEF_NREQ);
        int idx;
        rr_pick = last;
        for (int k = 16; k >= 1; k--) begin
            idx = last + k >= nreq ? last + k - nreq : last + k;
            if (k <= nreq && req[4'(idx)]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/ar_rr_pick.sv
// ar_rr_pick: combinational round-robin priority encoder starting after the last-served index
module ar_rr_pick
    import ar_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int L2NREQ = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]   req_i,
    input  logic [L2NREQ-1:0] last_i,
    output logic [L2NREQ-1:0] idx_o,
    output logic              any_o
);
    assign any_o = |req_i;
    assign idx_o = L2NREQ'(rr_pick(16'(req_i), int'(last_i), NREQ));
endmodule

// File: rtl/ar_fifo_merge_arb.sv
// ar_fifo_merge_arb: round-robin, message-atomic sharing of one FIFO enqueue port among NREQ producers
module ar_fifo_merge_arb
    import ar_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ = DEF_NREQ,
    parameter int L2NREQ = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLR,
    input  logic [NREQ-1:0]       REQ_ENQ,
    input  logic [NREQ-1:0]       REQ_EOP,
    input  logic [NREQ*WIDTH-1:0] REQ_DATA,
    output logic [NREQ-1:0]       REQ_RDY,
    output logic                  FIFO_ENQ,
    output logic [WIDTH:0]        FIFO_D_IN,
    input  logic                  FIFO_FULL_N,
    output logic                  GRANT_VLD,
    output logic [L2NREQ-1:0]     GRANT_ID,
    output logic [15:0]           MSG_CNT
);
    state_e state_q, state_d;
    logic [L2NREQ-1:0] gnt_q, gnt_d, last_q, last_d, pick;
    logic [15:0] cnt_q, cnt_d;
    logic any, busy, xfer, sel_enq, sel_eop;
    logic [WIDTH-1:0] sel_data;

    ar_rr_pick #(.NREQ(NREQ), .L2NREQ(L2NREQ)) u_pick (
        .req_i (REQ_ENQ),
        .last_i(last_q),
        .idx_o (pick),
        .any_o (any)
    );

    always_comb begin
        sel_enq = 1'b0;
        sel_eop = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_q == L2NREQ'(i)) begin
                sel_enq = REQ_ENQ[i];
                sel_eop = REQ_EOP[i];
                sel_data = REQ_DATA[i*WIDTH +: WIDTH];
            end
    end

    assign busy = state_q == ST_BUSY;
    assign xfer = busy && sel_enq && FIFO_FULL_N;
    assign REQ_RDY = busy && FIFO_FULL_N ? NREQ'(1) << gnt_q : '0;
    assign FIFO_ENQ = xfer;
    assign FIFO_D_IN = {sel_eop, sel_data};
    assign GRANT_VLD = busy;
    assign GRANT_ID = gnt_q;
    assign MSG_CNT = cnt_q;

    // the arbitration cycle moves no data; the grant lasts until an accepted EOP word
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        last_d = last_q;
        cnt_d = cnt_q;
        if (!busy && any) begin
            state_d = ST_BUSY;
            gnt_d = pick;
        end
        if (xfer && sel_eop) begin
            state_d = ST_IDLE;
            last_d = gnt_q;
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK)
        if (!RST_N || CLR) begin
            state_q <= ST_IDLE;
            gnt_q <= '0;
            last_q <= L2NREQ'(NREQ - 1);
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
        end
endmodule
